// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: control/status bundle between the phase sequencer and the datapath.
// Breakpoint signals exist only when PHASE_SEQ_BREAKPOINT_EN is defined.
interface phase_sequencer_if #(parameter int CNT_W = 16);
    logic             run_req;
    logic             step_req;
    logic             halt_instr;
    logic             p4_mem_access;
    logic             mem_write_req;
    logic [2:0]       phase_counter;
    logic             op_mem_src;
    logic             op_mem_write;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
`ifdef PHASE_SEQ_BREAKPOINT_EN
    logic             bp_en;
    logic [15:0]      bp_addr;
    logic [15:0]      pc;
    logic             bp_hit;
    modport master (output run_req, step_req, halt_instr, p4_mem_access, mem_write_req, bp_en, bp_addr, pc,
                    input phase_counter, op_mem_src, op_mem_write, running, halted, instr_count, bp_hit);
    modport slave (input run_req, step_req, halt_instr, p4_mem_access, mem_write_req, bp_en, bp_addr, pc,
                   output phase_counter, op_mem_src, op_mem_write, running, halted, instr_count, bp_hit);
`else
    modport master (output run_req, step_req, halt_instr, p4_mem_access, mem_write_req,
                    input phase_counter, op_mem_src, op_mem_write, running, halted, instr_count);
    modport slave (input run_req, step_req, halt_instr, p4_mem_access, mem_write_req,
                   output phase_counter, op_mem_src, op_mem_write, running, halted, instr_count);
`endif
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: 5-phase multicycle CPU sequencer with run/step/halt and memory wait states.
// Optional breakpoint logic enabled by defining PHASE_SEQ_BREAKPOINT_EN.
module phase_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic            clock,
    input  logic            reset,
    phase_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
    localparam logic [3:0] WAIT = 4'(MEM_WAIT);
    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             src_q, wr_q, run_prev_q, hold, bp_stop;
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = '0;
        count_d = count_q;
        hold    = phase_q == 3'd0 || (phase_q == 3'd3 && bus.p4_mem_access);
        if (state_q == IDLE) begin
            if (bus.run_req) begin
                state_d = RUN;
                phase_d = 3'd0;
            end else if (bus.step_req) begin
                state_d = STEP;
                phase_d = 3'd0;
            end
        end else if (state_q == HALTED) begin
            if (bus.run_req && !run_prev_q) begin
                state_d = RUN;
                phase_d = 3'd0;
            end
        end else if (hold && wait_q != WAIT) begin
            wait_d = wait_q + 4'd1;
        end else if (phase_q != 3'd4) begin
            phase_d = phase_q + 3'd1;
        end else begin
            count_d = count_q + CNT_W'(1);
            state_d = bus.halt_instr ? HALTED : IDLE;
            phase_d = 3'd7;
            if (!bus.halt_instr && state_q == RUN && bus.run_req && !bp_stop) begin
                state_d = RUN;
                phase_d = 3'd0;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= 3'd7;
            wait_q     <= '0;
            count_q    <= '0;
            src_q      <= 1'b0;
            wr_q       <= 1'b0;
            run_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wait_q     <= wait_d;
            count_q    <= count_d;
            src_q      <= phase_d == 3'd3 && bus.p4_mem_access;
            wr_q       <= phase_d == 3'd3 && phase_q != 3'd3 && bus.p4_mem_access && bus.mem_write_req;
            run_prev_q <= bus.run_req;
        end
    end
`ifdef PHASE_SEQ_BREAKPOINT_EN
    logic skip_q, bp_hit_q;
    // the first boundary after leaving IDLE never re-triggers the same breakpoint
    assign bp_stop = bus.bp_en && bus.pc == bus.bp_addr && !skip_q;
    always_ff @(posedge clock) begin
        if (!reset) begin
            skip_q   <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d != IDLE) begin
                skip_q   <= 1'b1;
                bp_hit_q <= 1'b0;
            end else if ((state_q == RUN || state_q == STEP) && phase_q == 3'd4) begin
                skip_q <= 1'b0;
            end
            if (state_q == RUN && phase_q == 3'd4 && bus.run_req && !bus.halt_instr && bp_stop)
                bp_hit_q <= 1'b1;
        end
    end
    assign bus.bp_hit = bp_hit_q;
`else
    assign bp_stop = 1'b0;
`endif
    assign bus.phase_counter = phase_q;
    assign bus.op_mem_src    = src_q;
    assign bus.op_mem_write  = wr_q;
    assign bus.running       = state_q == RUN || state_q == STEP;
    assign bus.halted        = state_q == HALTED;
    assign bus.instr_count   = count_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed self-checking bench for phase_sequencer (MEM_WAIT 0 and 2 instances).
module tb_phase_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    always #5 clock = ~clock;
    phase_sequencer_if #(.CNT_W(16)) b0 ();
    phase_sequencer_if #(.CNT_W(16)) b2 ();
    phase_sequencer #(.MEM_WAIT(0), .CNT_W(16)) dut0 (.clock(clock), .reset(reset), .bus(b0));
    phase_sequencer #(.MEM_WAIT(2), .CNT_W(16)) dut2 (.clock(clock), .reset(reset), .bus(b2));
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        logic [2:0] ep [9];
        logic       es [9];
        logic       ew [9];
        ep = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        {b0.run_req, b0.step_req, b0.halt_instr, b0.p4_mem_access, b0.mem_write_req} = '0;
        {b2.run_req, b2.step_req, b2.halt_instr, b2.p4_mem_access, b2.mem_write_req} = '0;
`ifdef PHASE_SEQ_BREAKPOINT_EN
        b0.bp_en = 1'b0; b0.bp_addr = '0; b0.pc = '0;
        b2.bp_en = 1'b0; b2.bp_addr = '0; b2.pc = '0;
`endif
        tick();
        tick();
        chk("rst_phase", 32'(b0.phase_counter), 32'd7);
        chk("rst_count", 32'(b0.instr_count), 32'd0);
        chk("rst_running", 32'(b0.running), 32'd0);
        chk("rst_halted", 32'(b0.halted), 32'd0);
        chk("rst_src", 32'(b0.op_mem_src), 32'd0);
        chk("rst_wr", 32'(b0.op_mem_write), 32'd0);
        chk("rst_phase_w2", 32'(b2.phase_counter), 32'd7);
        reset = 1'b1;
        b2.p4_mem_access = 1'b1;
        b2.mem_write_req = 1'b1;
        b2.run_req = 1'b1;
        tick();
        b2.run_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            chk($sformatf("w2_phase[%0d]", i), 32'(b2.phase_counter), 32'(ep[i]));
            chk($sformatf("w2_src[%0d]", i), 32'(b2.op_mem_src), 32'(es[i]));
            chk($sformatf("w2_wr[%0d]", i), 32'(b2.op_mem_write), 32'(ew[i]));
        end
        tick();
        chk("w2_end_phase", 32'(b2.phase_counter), 32'd7);
        chk("w2_end_count", 32'(b2.instr_count), 32'd1);
        b2.p4_mem_access = 1'b0;
        b2.mem_write_req = 1'b0;
        b0.run_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("run_phase[%0d]", i), 32'(b0.phase_counter), 32'(i % 5));
        end
        tick();
        chk("run_nobubble", 32'(b0.phase_counter), 32'd0);
        chk("run_count3", 32'(b0.instr_count), 32'd3);
        b0.run_req = 1'b0;
        tick();
        tick();
        chk("run_drop_running", 32'(b0.running), 32'd1);
        tick();
        tick();
        tick();
        chk("run_stop_phase", 32'(b0.phase_counter), 32'd7);
        chk("run_stop_count", 32'(b0.instr_count), 32'd4);
        chk("run_stop_running", 32'(b0.running), 32'd0);
        b0.step_req = 1'b1;
        tick();
        b0.step_req = 1'b0;
        chk("step_phase0", 32'(b0.phase_counter), 32'd0);
        chk("step_running", 32'(b0.running), 32'd1);
        tick();
        b0.step_req = 1'b1;
        tick();
        b0.step_req = 1'b0;
        chk("step_phase2", 32'(b0.phase_counter), 32'd2);
        tick();
        tick();
        chk("step_phase4", 32'(b0.phase_counter), 32'd4);
        tick();
        chk("step_end_phase", 32'(b0.phase_counter), 32'd7);
        chk("step_end_count", 32'(b0.instr_count), 32'd5);
        tick();
        chk("step_noqueue_phase", 32'(b0.phase_counter), 32'd7);
        chk("step_noqueue_count", 32'(b0.instr_count), 32'd5);
        b0.run_req = 1'b1;
        b0.halt_instr = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("halt_p4", 32'(b0.phase_counter), 32'd4);
        tick();
        chk("halt_phase", 32'(b0.phase_counter), 32'd7);
        chk("halt_halted", 32'(b0.halted), 32'd1);
        chk("halt_running", 32'(b0.running), 32'd0);
        chk("halt_count", 32'(b0.instr_count), 32'd6);
        tick();
        tick();
        tick();
        chk("halt_hold_level", 32'(b0.halted), 32'd1);
        chk("halt_hold_phase", 32'(b0.phase_counter), 32'd7);
        b0.halt_instr = 1'b0;
        b0.run_req = 1'b0;
        tick();
        chk("halt_run_low", 32'(b0.halted), 32'd1);
        b0.run_req = 1'b1;
        tick();
        chk("resume_phase", 32'(b0.phase_counter), 32'd0);
        chk("resume_halted", 32'(b0.halted), 32'd0);
        chk("resume_running", 32'(b0.running), 32'd1);
        b0.run_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("resume_end_phase", 32'(b0.phase_counter), 32'd7);
        chk("resume_end_count", 32'(b0.instr_count), 32'd7);
`ifdef PHASE_SEQ_BREAKPOINT_EN
        b0.bp_en = 1'b1;
        b0.bp_addr = 16'h0004;
        b0.pc = 16'h0004;
        b0.run_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_first_skip", 32'(b0.phase_counter), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_phase", 32'(b0.phase_counter), 32'd7);
        chk("bp_hit", 32'(b0.bp_hit), 32'd1);
        chk("bp_running", 32'(b0.running), 32'd0);
        chk("bp_count", 32'(b0.instr_count), 32'd9);
        b0.run_req = 1'b0;
        b0.step_req = 1'b1;
        tick();
        b0.step_req = 1'b0;
        chk("bp_step_phase", 32'(b0.phase_counter), 32'd0);
        chk("bp_step_clear", 32'(b0.bp_hit), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_step_end", 32'(b0.phase_counter), 32'd7);
        chk("bp_step_count", 32'(b0.instr_count), 32'd10);
        b0.bp_en = 1'b0;
`endif
        b0.p4_mem_access = 1'b1;
        b0.mem_write_req = 1'b1;
        b0.run_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mrst_pre_phase", 32'(b0.phase_counter), 32'd3);
        chk("mrst_pre_wr", 32'(b0.op_mem_write), 32'd1);
        chk("mrst_pre_src", 32'(b0.op_mem_src), 32'd1);
        reset = 1'b0;
        tick();
        chk("mrst_phase", 32'(b0.phase_counter), 32'd7);
        chk("mrst_wr", 32'(b0.op_mem_write), 32'd0);
        chk("mrst_src", 32'(b0.op_mem_src), 32'd0);
        chk("mrst_count", 32'(b0.instr_count), 32'd0);
        chk("mrst_running", 32'(b0.running), 32'd0);
        reset = 1'b1;
        b0.run_req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Drives the 5-phase multicycle CPU sequence (p1 fetch ... p5 writeback/PC update) consumed by the fetch/memory-access stage and the rest of the datapath. It generates phase_counter and the memory-port source select, and gates memory writes to exactly one cycle. It provides run/stop/single-step/halt control and inserts configurable memory wait states in the memory phases p1 and p4.

Parameters:
MEM_WAIT, 0, extra hold cycles added to p1 and to memory-using p4 (0..15)
CNT_W, 16, width of retired-instruction counter

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  reset, synchronous, active-low
run_req  input  1  level; 1 = free-run, 0 = stop at the next instruction boundary
step_req  input  1  one-cycle pulse; executes exactly one instruction when idle
halt_instr  input  1  decoded HLT; sampled in the last cycle of p5
p4_mem_access  input  1  decoded instruction uses memory in p4 (load/store)
mem_write_req  input  1  decoded store
phase_counter  output  3  0..4 = p1..p5; 3'b111 = inactive
op_mem_src  output  1  1 only while phase_counter==3'd3 and p4_mem_access==1
op_mem_write  output  1  store write strobe
running  output  1  1 while state is RUN or STEP
halted  output  1  1 in state HALTED
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, RUN, STEP, HALTED. Reset (reset==0 at a rising edge) → IDLE, phase_counter=3'b111, wait counter=0, instr_count=0, op_mem_src=0, op_mem_write=0, running=0, halted=0. Reset mid-instruction aborts immediately.
- IDLE: phase_counter=3'b111.
  - run_req=1 → RUN, phase 0 next cycle.
  - else step_req=1 → STEP, phase 0 next cycle.
  - run_req has priority when both are 1.
- RUN/STEP: each phase normally lasts 1 cycle; 0→1→2→3→4.
- Wait states: in phase 0, and in phase 3 when p4_mem_access=1, the phase is held for 1+MEM_WAIT cycles using a wait counter. The counter is cleared on every phase change. With MEM_WAIT=0, an instruction takes exactly 5 cycles.
- op_mem_write=1 only in the first cycle of phase 3 when p4_mem_access & mem_write_req; otherwise 0. Never asserted outside phase 3, in IDLE, or in HALTED.
- Last cycle of phase 4 (instruction boundary):
  - instr_count += 1, wrapping all-ones → 0.
  - halt_instr=1 → HALTED. Halt has priority over run and step.
  - else STEP → IDLE.
  - else RUN with run_req=1 → phase 0, no bubble cycle.
  - else RUN with run_req=0 → IDLE.
- run_req dropping mid-instruction does not abort; the current instruction completes.
- step_req during RUN/STEP/HALTED is ignored and not queued.
- HALTED: phase_counter=3'b111, halted=1. Exits to RUN only on a run_req 0→1 edge (edge detector register, cleared at reset). A level held high across the halt does not restart.
- Outputs are registered. phase_counter changes only on rising edges, so datapath falling-edge samples see stable values.

Optional Feature:
Macro PHASE_SEQ_BREAKPOINT_EN.
- When defined, adds ports: bp_en input 1, bp_addr input 16, pc input 16, bp_hit output 1.
- At each instruction boundary where the sequencer would enter phase 0 from RUN: if bp_en & pc==bp_addr, go to IDLE instead and set sticky bp_hit=1.
- bp_hit clears on reset or on leaving IDLE. Leaving IDLE via run_req or step_req does not re-check the same address for that first instruction.
- When not defined: ports absent, no breakpoint logic.

Test Plan:
- Reset then run_req=1, MEM_WAIT=0, no memory ops → phase_counter 0,1,2,3,4,0… each 1 cycle; instr_count=3 after 15 cycles.
- MEM_WAIT=2, p4_mem_access=1, mem_write_req=1 → phase 0 held 3 cycles, phase 3 held 3 cycles; op_mem_src=1 for those 3 cycles; op_mem_write=1 for exactly the first.
- Idle, single-cycle step_req → exactly one 0..4 sequence, then phase_counter=3'b111 and instr_count=1; step_req during execution produces no second instruction.
- halt_instr=1 at p5 while run_req held 1 → HALTED, halted=1, stays halted; run_req 1→0→1 → resumes at phase 0.
- reset=0 asserted in phase 3 with op_mem_write pending → next cycle phase_counter=3'b111, op_mem_write=0, instr_count=0.
- With PHASE_SEQ_BREAKPOINT_EN, bp_en=1, bp_addr=16'h0004, pc reaching 16'h0004 at a boundary → IDLE, bp_hit=1; step_req executes that instruction and clears bp_hit.
